kernel_bank_ctrl: RTL
=====================

KERNEL_BANK_CTRL -- requirements
Module: kernel_bank_ctrl

Interface
REQ-001 SHALL have parameter K_DIM, default 3, meaning kernel dimension (rows = columns).
REQ-002 SHALL have parameter M_BITS, default 16, meaning width of one floating-point kernel element.
REQ-003 SHALL have parameter N_BANK, default 2, meaning number of kernel banks held in FIFO order (minimum 2).
REQ-004 SHALL have port clk, input, 1, meaning the single clock for all logic.
REQ-005 SHALL have port rst, input, 1, meaning reset, synchronous and active-high.
REQ-006 SHALL have port in_data, input, [K_DIM][M_BITS], meaning one kernel row per beat, element j in slot j.
REQ-007 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_last (input, 1), meaning AXI-Stream slave handshake; in_last marks the final row of a kernel.
REQ-008 SHALL have port out_data, output, [K_DIM][K_DIM][M_BITS], meaning the kernel at the FIFO head.
REQ-009 SHALL have ports out_valid (output, 1) and out_release (input, 1), meaning the head kernel is valid, and the consumer has finished with it.
REQ-010 SHALL have port flush, input, 1, meaning drop all stored kernels and abort any partial load.
REQ-011 SHALL have port k_count, output, $clog2(N_BANK+1), meaning the number of committed kernels stored.
REQ-012 SHALL have ports err_short and err_long, output, 1 each, meaning single-cycle pulses for malformed packets.

Function
REQ-013 SHALL accept a beat only on the cycle where in_valid && in_ready.
REQ-014 SHALL drive in_ready = 0 while rst=1; otherwise 1 in DISCARD, else 1 iff k_count < N_BANK. in_ready SHALL depend on registered state only, never combinationally on in_valid.
REQ-015 SHALL use write-side states LOAD and DISCARD; reset state is LOAD with row counter = 0.
REQ-016 LOAD, accepted beat: SHALL write in_data into bank[wr_ptr] row [row].
REQ-017 LOAD, beat with in_last at row == K_DIM-1: SHALL commit the kernel, advance wr_ptr modulo N_BANK, and set row = 0.
REQ-018 LOAD, beat with in_last at row < K_DIM-1: SHALL discard the partial kernel, leave wr_ptr and k_count unchanged, set row = 0, and pulse err_short the next cycle.
REQ-019 LOAD, beat without in_last at row == K_DIM-1: SHALL discard the partial kernel, set row = 0, go to DISCARD, and pulse err_long the next cycle.
REQ-020 LOAD, beat without in_last at row < K_DIM-1: SHALL increment row.
REQ-021 DISCARD: SHALL accept and drop beats without writing storage; an accepted beat with in_last SHALL return to LOAD.
REQ-022 SHALL drive out_valid = (k_count > 0) and out_data = bank[rd_ptr], both registered-state based; out_data is don't-care while out_valid = 0.
REQ-023 SHALL pop the head when out_release && out_valid (rd_ptr advances modulo N_BANK, k_count decrements) and ignore out_release while out_valid = 0.
REQ-024 A committed kernel SHALL appear on out_valid/k_count on the cycle after its last beat is accepted (latency 1).
REQ-025 On a commit and a pop in the same cycle, k_count SHALL be unchanged and both pointers SHALL advance.
REQ-026 Full (k_count == N_BANK) SHALL deassert in_ready in LOAD without corrupting stored banks; a pop SHALL reassert it on the next cycle.
REQ-027 On flush: k_count, wr_ptr, rd_ptr and row SHALL be set to 0; state SHALL go to DISCARD if in LOAD with row != 0 or already in DISCARD, else LOAD. A same-cycle beat or release SHALL be ignored; flush SHALL take priority over them.
REQ-028 Pointer wrap SHALL be correct for non-power-of-two N_BANK.

Reset
REQ-029 While rst = 1 at a clk edge, the block SHALL set state = LOAD, row = 0, wr_ptr = rd_ptr = 0, k_count = 0, out_valid = 0, err_short = err_long = 0, and in_ready = 0.
REQ-030 Bank storage SHALL be cleared to 0 on reset.
REQ-031 Reset asserted mid-packet SHALL abandon the packet; after release, the next beat SHALL be treated as row 0 in LOAD.

Verification (K_DIM=3, N_BANK=2, M_BITS=16)
REQ-032 Rows {1,2,3},{4,5,6},{7,8,9} with last on row 3 -> out_valid=1 and k_count=1 one cycle later; out_data[2][1]=8.
REQ-033 Load 2 kernels with no release -> in_ready=0; pulse out_release -> next cycle k_count=1, in_ready=1, out_data = second kernel.
REQ-034 2-row packet with last on row 2 -> err_short pulses for 1 cycle, k_count stays 0; a following valid 3-row packet commits normally.
REQ-035 5-row packet with last on row 5 -> err_long pulses once, rows 4-5 dropped, k_count=0; the next packet loads from row 0.
REQ-036 k_count=1, commit of kernel 2 on the same cycle as out_release -> k_count stays 1 and out_data = kernel 2.
REQ-037 flush after row 1 of a packet -> k_count=0, rows 2-3 dropped through last, next packet commits; rst mid-packet -> all outputs at reset values.

Source files
------------

// File: rtl/kernel_bank_ctrl.sv
// Kernel bank controller: assembles row-streamed KxK kernels into an N-deep FIFO of banks
// and presents the head kernel to a consumer until it is released.
module kernel_bank_ctrl #(
   parameter int unsigned K_DIM  = 3,
   parameter int unsigned M_BITS = 16,
   parameter int unsigned N_BANK = 2
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic [K_DIM-1:0][M_BITS-1:0]                in_data,
   input  logic                                        in_valid,
   output logic                                        in_ready,
   input  logic                                        in_last,
   output logic [K_DIM-1:0][K_DIM-1:0][M_BITS-1:0]     out_data,
   output logic                                        out_valid,
   input  logic                                        out_release,
   input  logic                                        flush,
   output logic [$clog2(N_BANK+1)-1:0]                 k_count,
   output logic                                        err_short,
   output logic                                        err_long
);

   localparam int unsigned ROW_W = (K_DIM > 1) ? $clog2(K_DIM) : 1;
   localparam int unsigned PTR_W = $clog2(N_BANK);
   localparam int unsigned CNT_W = $clog2(N_BANK + 1);

   localparam logic [ROW_W-1:0] L_ROW_LAST = ROW_W'(K_DIM - 1);
   localparam logic [PTR_W-1:0] L_PTR_LAST = PTR_W'(N_BANK - 1);
   localparam logic [CNT_W-1:0] L_FULL     = CNT_W'(N_BANK);

   typedef enum logic [0:0] {StLoad, StDiscard} state_e;

   state_e                                      r_state, w_state_d;
   logic [ROW_W-1:0]                            r_row, w_row_d;
   logic [PTR_W-1:0]                            r_wr_ptr, w_wr_ptr_d;
   logic [PTR_W-1:0]                            r_rd_ptr, w_rd_ptr_d;
   logic [CNT_W-1:0]                            r_k_count, w_k_count_d;
   logic                                        r_err_short, w_err_short_d;
   logic                                        r_err_long, w_err_long_d;
   logic [K_DIM-1:0][K_DIM-1:0][M_BITS-1:0]     r_bank [N_BANK];

   logic w_accept;
   logic w_pop;
   logic w_commit;
   logic w_wr_en;

   // Wrap explicitly so non-power-of-two bank counts cycle correctly.
   function automatic logic [PTR_W-1:0] f_ptr_inc(input logic [PTR_W-1:0] p);
      return (p == L_PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   assign in_ready  = !rst && ((r_state == StDiscard) || (r_k_count != L_FULL));
   assign out_valid = (r_k_count != '0);
   assign out_data  = r_bank[r_rd_ptr];
   assign k_count   = r_k_count;
   assign err_short = r_err_short;
   assign err_long  = r_err_long;

   assign w_accept = in_valid && in_ready;
   assign w_pop    = out_release && out_valid && !flush;

   always_comb begin
      w_state_d     = r_state;
      w_row_d       = r_row;
      w_commit      = 1'b0;
      w_wr_en       = 1'b0;
      w_err_short_d = 1'b0;
      w_err_long_d  = 1'b0;
      if (flush) begin
         w_row_d   = '0;
         // A half-loaded packet still has rows in flight; swallow them up to its last beat.
         w_state_d = ((r_state == StDiscard) || (r_row != '0)) ? StDiscard : StLoad;
      end else if (w_accept) begin
         unique case (r_state)
            StLoad: begin
               w_wr_en = 1'b1;
               if (in_last) begin
                  w_row_d = '0;
                  if (r_row == L_ROW_LAST) w_commit = 1'b1;
                  else w_err_short_d = 1'b1;
               end else if (r_row == L_ROW_LAST) begin
                  w_row_d      = '0;
                  w_state_d    = StDiscard;
                  w_err_long_d = 1'b1;
               end else begin
                  w_row_d = r_row + 1'b1;
               end
            end
            StDiscard: begin
               if (in_last) w_state_d = StLoad;
            end
            default: w_state_d = StLoad;
         endcase
      end
   end

   always_comb begin
      w_wr_ptr_d  = r_wr_ptr;
      w_rd_ptr_d  = r_rd_ptr;
      w_k_count_d = r_k_count;
      if (flush) begin
         w_wr_ptr_d  = '0;
         w_rd_ptr_d  = '0;
         w_k_count_d = '0;
      end else begin
         if (w_commit) w_wr_ptr_d = f_ptr_inc(r_wr_ptr);
         if (w_pop) w_rd_ptr_d = f_ptr_inc(r_rd_ptr);
         unique case ({w_commit, w_pop})
            2'b10:   w_k_count_d = r_k_count + 1'b1;
            2'b01:   w_k_count_d = r_k_count - 1'b1;
            default: w_k_count_d = r_k_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= StLoad;
         r_row       <= '0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_k_count   <= '0;
         r_err_short <= 1'b0;
         r_err_long  <= 1'b0;
         for (int b = 0; b < N_BANK; b++) r_bank[b] <= '0;
      end else begin
         r_state     <= w_state_d;
         r_row       <= w_row_d;
         r_wr_ptr    <= w_wr_ptr_d;
         r_rd_ptr    <= w_rd_ptr_d;
         r_k_count   <= w_k_count_d;
         r_err_short <= w_err_short_d;
         r_err_long  <= w_err_long_d;
         if (w_wr_en) r_bank[r_wr_ptr][r_row] <= in_data;
      end
   end

endmodule
